token_rr_arbiter: RTL and testbench



---
 rtl/token_rr_arbiter.sv | 105 ++++++++++
 tb/tb_token_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/token_rr_arbiter.sv
// Round-robin drain stage for a bank of dataless token FIFOs: dequeues at most
// one FIFO per cycle and presents the winning source index on a registered output.
module token_rr_arbiter #(
    parameter int n_src     = 4,
    parameter int idx_width = 2,
    parameter int p_burst   = 2,
    parameter int cnt_width = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic [n_src-1:0]     EMPTY_N,
    output logic [n_src-1:0]     DEQ,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [idx_width-1:0] OUT_IDX
);

    // Output handshake: a token transfers on any rising edge where OUT_VALID and
    // OUT_READY are both high; OUT_IDX is held unchanged while OUT_VALID && !OUT_READY.

    localparam logic [cnt_width-1:0] cnt_max  = cnt_width'(p_burst - 1);
    localparam logic [idx_width-1:0] last_rst = idx_width'(n_src - 1);

    logic [idx_width-1:0] last_idx;
    logic [cnt_width-1:0] burst_cnt;
    // Burst hold is only eligible once a grant has happened since reset/clear,
    // so the first grant always starts the rotation at source 0.
    logic                 granted;

    logic                 load;
    logic                 any_req;
    logic                 grant;
    logic                 hold_ok;
    logic                 found;
    logic [idx_width-1:0] search_idx;
    logic [idx_width-1:0] winner;
    logic [cnt_width-1:0] cnt_next;

    assign load    = !OUT_VALID || OUT_READY;
    assign any_req = |EMPTY_N;
    assign grant   = load && any_req && !CLR;
    assign hold_ok = granted && EMPTY_N[last_idx] && (burst_cnt < cnt_max);

    always_comb begin
        int cand;
        cand       = 0;
        found      = 1'b0;
        search_idx = last_idx;
        for (int k = 1; k <= n_src; k++) begin
            cand = (int'(last_idx) + k) % n_src;
            if (!found && EMPTY_N[cand]) begin
                found      = 1'b1;
                search_idx = idx_width'(cand);
            end
        end
    end

    assign winner = hold_ok ? last_idx : search_idx;

    // Saturating at p_burst-1 keeps the hold decision unchanged while avoiding wrap.
    always_comb begin
        cnt_next = '0;
        if (winner == last_idx) begin
            cnt_next = (burst_cnt >= cnt_max) ? cnt_max : burst_cnt + 1'b1;
        end
    end

    assign DEQ = (grant && RST) ? (n_src'(1) << winner) : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_VALID <= 1'b0;
            OUT_IDX   <= '0;
            last_idx  <= last_rst;
            burst_cnt <= '0;
            granted   <= 1'b0;
        end else if (CLR) begin
            OUT_VALID <= 1'b0;
            OUT_IDX   <= '0;
            last_idx  <= last_rst;
            burst_cnt <= '0;
            granted   <= 1'b0;
        end else if (load) begin
            if (any_req) begin
                OUT_VALID <= 1'b1;
                OUT_IDX   <= winner;
                last_idx  <= winner;
                burst_cnt <= cnt_next;
                granted   <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

    a_deq_onehot : assert property (@(posedge CLK) disable iff (!RST) $onehot0(DEQ))
        else $warning("DEQ has more than one bit set: %b", DEQ);

    a_idx_stable : assert property (@(posedge CLK) disable iff (!RST)
        (OUT_VALID && !OUT_READY && !CLR) |=> $stable(OUT_IDX))
        else $warning("OUT_IDX changed while stalled");

endmodule

// File: tb/tb_token_rr_arbiter.sv
// Directed bench for token_rr_arbiter: a burst instance (p_burst=2) and a pure
// round-robin instance (p_burst=1) share inputs; expectations are hand-computed.
module tb_token_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [3:0] empty_n;
    logic       ready;
    logic [3:0] deq;
    logic       valid;
    logic [1:0] idx;
    logic [3:0] rr_deq;
    logic       rr_valid;
    logic [1:0] rr_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] empty_n;
        logic       ready;
        logic       clr;
        logic [3:0] deq;
        logic       valid;
        logic [1:0] idx;
        logic       chk_rr;
        logic [3:0] rr_deq;
        logic       rr_valid;
        logic [1:0] rr_idx;
    } vec_t;

    vec_t vecs[$];

    token_rr_arbiter #(.n_src(4), .idx_width(2), .p_burst(2), .cnt_width(2)) u_dut (
        .CLK(clk), .RST(rst_n), .CLR(clr), .EMPTY_N(empty_n), .DEQ(deq),
        .OUT_VALID(valid), .OUT_READY(ready), .OUT_IDX(idx)
    );

    token_rr_arbiter #(.n_src(4), .idx_width(2), .p_burst(1), .cnt_width(2)) u_rr (
        .CLK(clk), .RST(rst_n), .CLR(clr), .EMPTY_N(empty_n), .DEQ(rr_deq),
        .OUT_VALID(rr_valid), .OUT_READY(ready), .OUT_IDX(rr_idx)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] e, input logic r, input logic c,
                       input logic [3:0] d, input logic v, input logic [1:0] i);
        vec_t t;
        t = '{e, r, c, d, v, i, 1'b0, 4'b0, 1'b0, 2'b0};
        vecs.push_back(t);
    endtask

    task automatic add_rr(input logic [3:0] e, input logic [3:0] d, input logic v,
                          input logic [1:0] i, input logic [3:0] rd, input logic rv,
                          input logic [1:0] ri);
        vec_t t;
        t = '{e, 1'b1, 1'b0, d, v, i, 1'b1, rd, rv, ri};
        vecs.push_back(t);
    endtask

    // Each vector: drive at negedge, then compare registered outputs (state from
    // the previous edge) and the combinational DEQ for the current inputs.
    task automatic run_vecs(input int lo, input int hi);
        for (int n = lo; n < hi; n++) begin
            @(negedge clk);
            empty_n = vecs[n].empty_n;
            ready   = vecs[n].ready;
            clr     = vecs[n].clr;
            #1;
            check($sformatf("v%0d deq", n), {4'b0, deq}, {4'b0, vecs[n].deq});
            check($sformatf("v%0d valid", n), {7'b0, valid}, {7'b0, vecs[n].valid});
            if (vecs[n].valid)
                check($sformatf("v%0d idx", n), {6'b0, idx}, {6'b0, vecs[n].idx});
            check($sformatf("v%0d deq_subset", n), {4'b0, deq & ~empty_n}, 8'h00);
            if (vecs[n].chk_rr) begin
                check($sformatf("v%0d rr_deq", n), {4'b0, rr_deq}, {4'b0, vecs[n].rr_deq});
                check($sformatf("v%0d rr_valid", n), {7'b0, rr_valid}, {7'b0, vecs[n].rr_valid});
                if (vecs[n].rr_valid)
                    check($sformatf("v%0d rr_idx", n), {6'b0, rr_idx}, {6'b0, vecs[n].rr_idx});
            end
        end
    endtask

    task automatic idle_after_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b1;
        empty_n = 4'b0000;
        ready   = 1'b1;
        clr     = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s idle%0d valid", tag, n), {7'b0, valid}, 8'h00);
            check($sformatf("%s idle%0d deq", tag, n), {4'b0, deq}, 8'h00);
        end
    endtask

    initial begin
        int n_ph1;
        rst_n   = 1'b0;
        clr     = 1'b0;
        empty_n = 4'b1111;
        ready   = 1'b1;

        // Phase 1: idle, then burst round-robin on u_dut and pure round-robin on u_rr.
        add_rr(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0);
        add_rr(4'b1111, 4'b0001, 0, 0, 4'b0001, 0, 0);
        add_rr(4'b1111, 4'b0001, 1, 0, 4'b0010, 1, 0);
        add_rr(4'b1111, 4'b0010, 1, 0, 4'b0100, 1, 1);
        add_rr(4'b1111, 4'b0010, 1, 1, 4'b1000, 1, 2);
        add_rr(4'b1111, 4'b0100, 1, 1, 4'b0001, 1, 3);
        add_rr(4'b1111, 4'b0100, 1, 2, 4'b0010, 1, 0);
        add_rr(4'b1111, 4'b1000, 1, 2, 4'b0100, 1, 1);
        add_rr(4'b1111, 4'b1000, 1, 3, 4'b1000, 1, 2);
        add_rr(4'b1111, 4'b0001, 1, 3, 4'b0001, 1, 3);
        add_rr(4'b1111, 4'b0001, 1, 0, 4'b0010, 1, 0);
        n_ph1 = vecs.size();

        // Phase 2: backpressure while OUT_IDX=1, then continue 1,2,2.
        add(4'b1111, 1, 0, 4'b0001, 0, 0);
        add(4'b1111, 1, 0, 4'b0001, 1, 0);
        add(4'b1111, 1, 0, 4'b0010, 1, 0);
        add(4'b1111, 0, 0, 4'b0000, 1, 1);
        add(4'b1111, 0, 0, 4'b0000, 1, 1);
        add(4'b1111, 0, 0, 4'b0000, 1, 1);
        add(4'b1111, 1, 0, 4'b0010, 1, 1);
        add(4'b1111, 1, 0, 4'b0100, 1, 1);
        add(4'b1111, 1, 0, 4'b0100, 1, 2);
        // Clear with OUT_IDX=2 held, then first grant is source 0.
        add(4'b1111, 1, 1, 4'b0000, 1, 2);
        add(4'b1111, 1, 0, 4'b0001, 0, 0);
        add(4'b1111, 1, 0, 4'b0001, 1, 0);
        add(4'b1111, 1, 1, 4'b0000, 1, 0);
        // Sparse: only source 2, then 4'b1010 rotates 3,3,1, then drain to idle.
        add(4'b0100, 1, 0, 4'b0100, 0, 0);
        add(4'b0100, 1, 0, 4'b0100, 1, 2);
        add(4'b0100, 1, 0, 4'b0100, 1, 2);
        add(4'b0100, 1, 0, 4'b0100, 1, 2);
        add(4'b1010, 1, 0, 4'b1000, 1, 2);
        add(4'b1010, 1, 0, 4'b1000, 1, 3);
        add(4'b1010, 1, 0, 4'b0010, 1, 3);
        add(4'b0000, 1, 0, 4'b0000, 1, 1);
        add(4'b0000, 1, 0, 4'b0000, 0, 0);

        // Reset held with requests pending: outputs cleared and DEQ gated.
        repeat (2) @(negedge clk);
        #1;
        check("reset valid", {7'b0, valid}, 8'h00);
        check("reset idx", {6'b0, idx}, 8'h00);
        check("reset deq", {4'b0, deq}, 8'h00);
        idle_after_reset("por");

        run_vecs(0, n_ph1);

        // Mid-stream asynchronous reset while a token is held.
        @(negedge clk);
        check("pre_reset valid", {7'b0, valid}, 8'h01);
        empty_n = 4'b1111;
        ready   = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("async_reset valid", {7'b0, valid}, 8'h00);
        check("async_reset deq", {4'b0, deq}, 8'h00);
        check("async_reset idx", {6'b0, idx}, 8'h00);
        check("async_reset rr_valid", {7'b0, rr_valid}, 8'h00);
        idle_after_reset("mid");

        run_vecs(n_ph1, vecs.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
